// File: rtl/spi_flash_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder_if
// Description : SPI pin bundle between a flash-reading master and the
//               spi_flash_responder slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_flash_responder_if;
    logic SPI_SCK;
    logic SPI_SS;
    logic SPI_MOSI;
    logic SPI_MISO;
    logic SPI_MISO_OE;

    modport master (
        output SPI_SCK,
        output SPI_SS,
        output SPI_MOSI,
        input  SPI_MISO,
        input  SPI_MISO_OE
    );

    modport slave (
        input  SPI_SCK,
        input  SPI_SS,
        input  SPI_MOSI,
        output SPI_MISO,
        output SPI_MISO_OE
    );
endinterface
`default_nettype wire

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_responder
// Description : Oversampled SPI mode-0 slave emulating the N25Q032A READ,
//               WREN, PAGE PROGRAM and RDSR commands over an internal memory.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int MEM_AW  = 12,
    parameter int PAGE_AW = 8
) (
    input  wire                  clk,
    input  wire                  reset,
    spi_flash_responder_if.slave spi,
    input  wire                  host_we,
    input  wire  [MEM_AW-1:0]    host_addr,
    input  wire  [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 prog_strobe,
    output logic [MEM_AW-1:0]    prog_addr,
    output logic [7:0]           prog_data,
    output logic                 busy,
    output logic                 wel
);

    typedef enum logic [3:0] {
        S_WAIT_SS_HIGH = 4'd0,
        S_IDLE         = 4'd1,
        S_CMD          = 4'd2,
        S_WREN_WAIT    = 4'd3,
        S_ADDR         = 4'd4,
        S_READ         = 4'd5,
        S_STATUS       = 4'd6,
        S_PROG         = 4'd7,
        S_IGNORE       = 4'd8
    } state_t;

    localparam logic [7:0] c_CMD_PP   = 8'h02;
    localparam logic [7:0] c_CMD_READ = 8'h03;
    localparam logic [7:0] c_CMD_RDSR = 8'h05;
    localparam logic [7:0] c_CMD_WREN = 8'h06;
    localparam logic [4:0] c_ADDR_LAST = 5'd23;

    state_t            r_state;
    state_t            w_next;

    logic              r_sck_s1, r_sck_s2, r_sck_s3;
    logic              r_ss_s1,  r_ss_s2;
    logic              r_mosi_s1, r_mosi_s2, r_mosi_s3;

    logic [4:0]        r_bitcnt;
    logic [6:0]        r_sh_in;
    logic [7:0]        r_sh_out;
    logic [MEM_AW-1:0] r_addr;
    logic              r_is_read;
    logic [1:0]        r_pf_cnt;
    logic              r_miso;
    logic [7:0]        r_mem_q;
    logic [7:0]        r_mem [2**MEM_AW];

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_ss_high;
    logic [7:0]        w_byte_in;
    logic              w_byte_done;
    logic              w_addr_done;
    logic [MEM_AW-1:0] w_addr_next;
    logic [7:0]        w_status;
    logic              w_spi_we;
    logic              w_shift_out;

    assign w_sck_rise  = r_sck_s2 & ~r_sck_s3;
    assign w_sck_fall  = ~r_sck_s2 & r_sck_s3;
    assign w_ss_high   = r_ss_s2;
    assign w_byte_in   = {r_sh_in, r_mosi_s3};
    assign w_byte_done = w_sck_rise && (r_bitcnt[2:0] == 3'd7);
    assign w_addr_done = w_sck_rise && (r_bitcnt == c_ADDR_LAST);
    assign w_addr_next = {r_addr[MEM_AW-2:0], r_mosi_s3};
    assign w_status    = {6'b0, wel, 1'b0};
    assign w_spi_we    = (r_state == S_PROG) && !w_ss_high && w_byte_done;
    assign w_shift_out = (r_state == S_READ) || (r_state == S_STATUS);

    assign spi.SPI_MISO    = r_miso;
    assign spi.SPI_MISO_OE = w_shift_out && !w_ss_high;

    // SS resets to "low" so a transfer already in progress at reset is ignored
    // until the master releases SS.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sck_s1   <= 1'b0;
            r_sck_s2   <= 1'b0;
            r_sck_s3   <= 1'b0;
            r_ss_s1    <= 1'b0;
            r_ss_s2    <= 1'b0;
            r_mosi_s1  <= 1'b0;
            r_mosi_s2  <= 1'b0;
            r_mosi_s3  <= 1'b0;
            r_mem_q    <= 8'h00;
            host_rdata <= 8'h00;
        end else begin
            r_sck_s1   <= spi.SPI_SCK;
            r_sck_s2   <= r_sck_s1;
            r_sck_s3   <= r_sck_s2;
            r_ss_s1    <= spi.SPI_SS;
            r_ss_s2    <= r_ss_s1;
            r_mosi_s1  <= spi.SPI_MOSI;
            r_mosi_s2  <= r_mosi_s1;
            r_mosi_s3  <= r_mosi_s2;
            r_mem_q    <= r_mem[r_addr];
            host_rdata <= r_mem[host_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_spi_we) begin
            r_mem[r_addr] <= w_byte_in;
        end else if (host_we) begin
            r_mem[host_addr] <= host_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_WAIT_SS_HIGH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_ss_high) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_CMD;
                S_CMD: begin
                    if (w_byte_done) begin
                        case (w_byte_in)
                            c_CMD_READ, c_CMD_PP: w_next = S_ADDR;
                            c_CMD_RDSR:           w_next = S_STATUS;
                            c_CMD_WREN:           w_next = S_WREN_WAIT;
                            default:              w_next = S_IGNORE;
                        endcase
                    end
                end
                S_WREN_WAIT: begin
                    if (w_sck_rise) begin
                        w_next = S_IGNORE;
                    end
                end
                S_ADDR: begin
                    if (w_addr_done) begin
                        if (r_is_read) begin
                            w_next = S_READ;
                        end else if (wel) begin
                            w_next = S_PROG;
                        end else begin
                            w_next = S_IGNORE;
                        end
                    end
                end
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt    <= 5'd0;
            r_sh_in     <= 7'd0;
            r_sh_out    <= 8'h00;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_pf_cnt    <= 2'd0;
            r_miso      <= 1'b0;
            prog_strobe <= 1'b0;
            prog_addr   <= '0;
            prog_data   <= 8'h00;
            busy        <= 1'b0;
            wel         <= 1'b0;
        end else begin
            prog_strobe <= 1'b0;
            busy        <= ~r_ss_s2;

            // Prefetch: address settles, registered read, then load the shifter.
            if (r_pf_cnt != 2'd0) begin
                r_pf_cnt <= r_pf_cnt - 2'd1;
            end
            if (r_pf_cnt == 2'd1) begin
                r_sh_out <= r_mem_q;
            end

            if (w_ss_high) begin
                r_bitcnt <= 5'd0;
                r_sh_in  <= 7'd0;
                r_miso   <= 1'b0;
                r_pf_cnt <= 2'd0;
                if (r_state == S_WREN_WAIT) begin
                    wel <= 1'b1;
                end else if (r_state == S_PROG) begin
                    wel <= 1'b0;
                end
            end else begin
                if (w_sck_rise) begin
                    r_sh_in <= w_byte_in[6:0];
                    if (r_state == S_ADDR) begin
                        r_bitcnt <= (r_bitcnt == c_ADDR_LAST) ? 5'd0 : r_bitcnt + 5'd1;
                    end else begin
                        r_bitcnt <= {2'b00, r_bitcnt[2:0] + 3'd1};
                    end
                end

                if (w_sck_fall && w_shift_out) begin
                    r_miso   <= r_sh_out[7];
                    r_sh_out <= {r_sh_out[6:0], 1'b0};
                end

                case (r_state)
                    S_CMD: begin
                        if (w_byte_done) begin
                            r_is_read <= (w_byte_in == c_CMD_READ);
                            if (w_byte_in == c_CMD_RDSR) begin
                                r_sh_out <= w_status;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_addr <= w_addr_next;
                            if (w_addr_done && r_is_read) begin
                                r_pf_cnt <= 2'd2;
                            end
                        end
                    end
                    S_READ: begin
                        if (w_byte_done) begin
                            r_addr   <= r_addr + MEM_AW'(1);
                            r_pf_cnt <= 2'd2;
                        end
                    end
                    S_STATUS: begin
                        if (w_byte_done) begin
                            r_sh_out <= w_status;
                        end
                    end
                    S_PROG: begin
                        if (w_byte_done) begin
                            prog_strobe <= 1'b1;
                            prog_addr   <= r_addr;
                            prog_data   <= w_byte_in;
                            // Only the in-page offset advances; the page stays put.
                            r_addr[PAGE_AW-1:0] <= r_addr[PAGE_AW-1:0] + PAGE_AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
